// File: rtl/tiny_rv_exec_ctrl_pkg.sv
// Shared types and constants for the tiny_rv execute-stage controller.
package tiny_rv_exec_pkg;

  localparam logic [6:0] RV_LUI  = 7'b0110111;
  localparam logic [6:0] RV_ALUI = 7'b0010011;
  localparam logic [6:0] RV_ALU  = 7'b0110011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, MD_RUN, RESP} exec_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
  } exec_req_t;

  function automatic logic is_md(input logic [6:0] op, input logic [6:0] f7);
    return (op == RV_ALU) && (f7 == F7_MULDIV);
  endfunction

endpackage

// File: rtl/tiny_rv_exec_ctrl_if.sv
// Issue, ALU and writeback signals of the execute controller; slave is the controller side.
interface tiny_rv_exec_ctrl_if;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm, alu_result;
  logic [6:0]  alu_opcode, alu_funct7;
  logic [2:0]  alu_funct3;
  logic        alu_active;
  logic        out_valid, out_ready, out_we, out_illegal;
  logic [31:0] out_data;
  logic [4:0]  out_rd;

  modport slave (
    input  in_valid, in_pc, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_rd,
    output in_ready,
    output alu_pc, alu_rs1, alu_rs2, alu_imm, alu_opcode, alu_funct3, alu_funct7,
    input  alu_result, alu_active,
    output out_valid, out_data, out_rd, out_we, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_pc, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_rd,
    input  in_ready,
    input  alu_pc, alu_rs1, alu_rs2, alu_imm, alu_opcode, alu_funct3, alu_funct7,
    output alu_result, alu_active,
    input  out_valid, out_data, out_rd, out_we, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/tiny_rv_muldiv_iter.sv
// Iterative RV32M unit: radix-2 shift-add multiply / restoring divide on magnitudes,
// one bit per cycle, signs applied combinationally in the final (done) cycle.
module tiny_rv_muldiv_iter
  import tiny_rv_exec_pkg::*;
#(
  parameter int MD_ITERS = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] result_o
);
  localparam int CW = $clog2(MD_ITERS + 1);

  logic          run_q, negq_q, negr_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    op_q;
  logic [31:0]   m_q;
  logic [63:0]   acc_q, acc_d, prod;
  logic          a_neg, b_neg;
  logic [31:0]   a_abs, b_abs, quo, rem;
  logic [32:0]   sum, rsh, diff;

  always_comb begin
    a_neg = a_i[31] & ((op_i == MD_MULH) | (op_i == MD_MULHSU) | (op_i == MD_DIV) | (op_i == MD_REM));
    b_neg = b_i[31] & ((op_i == MD_MULH) | (op_i == MD_DIV) | (op_i == MD_REM));
    a_abs = a_neg ? (32'd0 - a_i) : a_i;
    b_abs = b_neg ? (32'd0 - b_i) : b_i;
  end

  // Multiply: acc = {partial hi, multiplier}. Divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
    rsh  = {acc_q[63:32], acc_q[31]};
    diff = rsh - {1'b0, m_q};
    if (op_q[2]) acc_d = diff[32] ? {rsh[31:0], acc_q[30:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
    else         acc_d = {sum, acc_q[31:1]};
  end

  always_comb begin
    prod = negq_q ? (64'd0 - acc_q) : acc_q;
    quo  = negq_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem  = negr_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    case (op_q)
      MD_MUL:                      result_o = prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod[63:32];
      MD_DIV, MD_DIVU:             result_o = quo;
      default:                     result_o = rem;
    endcase
  end

  assign done_o = run_q && (cnt_q == CW'(MD_ITERS));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      run_q <= 1'b0; cnt_q <= '0; op_q <= '0; m_q <= '0; acc_q <= '0;
      negq_q <= 1'b0; negr_q <= 1'b0;
    end else if (abort_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      cnt_q  <= '0;
      op_q   <= op_i;
      m_q    <= op_i[2] ? b_abs : a_abs;
      acc_q  <= {32'd0, op_i[2] ? a_abs : b_abs};
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
    end else if (done_o) begin
      run_q <= 1'b0;
    end else if (run_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/tiny_rv_exec_ctrl.sv
// Execute-stage controller: holds operands on the ALU, sequences RV32M ops through the
// iterative unit, and returns one result per instruction to writeback.
module tiny_rv_exec_ctrl
  import tiny_rv_exec_pkg::*;
#(
  parameter int MD_ITERS = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  tiny_rv_exec_ctrl_if.slave  bus,
  output logic                busy
);
  exec_state_e state_q, state_d;
  exec_req_t   hold_q, hold_d, req;
  logic [31:0] res_q, res_d, md_result;
  logic        md_q, md_d, accept, md_start, md_done, resp, illegal;

  assign req = '{pc: bus.in_pc, opcode: bus.in_opcode, funct3: bus.in_funct3, funct7: bus.in_funct7,
                 rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm, rd: bus.in_rd};

  assign bus.in_ready = i_rst_n & ~i_flush & ((state_q == IDLE) | ((state_q == RESP) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    res_d    = res_q;
    md_d     = md_q;
    md_start = 1'b0;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      if ((state_q == MD_RUN) && md_done) begin
        res_d   = md_result;
        state_d = RESP;
      end
      if ((state_q == RESP) && bus.out_ready) state_d = IDLE;
      if (accept) begin
        hold_d  = req;
        md_d    = is_md(req.opcode, req.funct7);
        state_d = RESP;
        if (md_d) begin
          // Divide-by-zero and signed overflow are resolved here without iterating.
          if (req.funct3[2] && (req.rs2 == '0))
            res_d = req.funct3[1] ? req.rs1 : 32'hFFFF_FFFF;
          else if (req.funct3[2] && !req.funct3[0] && (req.rs1 == 32'h8000_0000) && (req.rs2 == 32'hFFFF_FFFF))
            res_d = req.funct3[1] ? 32'd0 : 32'h8000_0000;
          else begin
            state_d  = MD_RUN;
            md_start = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      res_q   <= '0;
      md_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      res_q   <= res_d;
      md_q    <= md_d;
    end
  end

  tiny_rv_muldiv_iter #(.MD_ITERS(MD_ITERS)) u_md (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .start_i  (md_start),
    .abort_i  (i_flush),
    .op_i     (hold_d.funct3),
    .a_i      (hold_d.rs1),
    .b_i      (hold_d.rs2),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign resp    = (state_q == RESP);
  assign illegal = resp & ~md_q & ~bus.alu_active;
  assign busy    = (state_q != IDLE);

  assign bus.out_valid   = resp;
  assign bus.out_data    = resp ? (md_q ? res_q : bus.alu_result) : 32'd0;
  assign bus.out_rd      = resp ? hold_q.rd : 5'd0;
  assign bus.out_illegal = illegal;
  assign bus.out_we      = resp & ~illegal & (hold_q.rd != 5'd0);

  assign bus.alu_pc     = hold_q.pc;
  assign bus.alu_rs1    = hold_q.rs1;
  assign bus.alu_rs2    = hold_q.rs2;
  assign bus.alu_imm    = hold_q.imm;
  assign bus.alu_opcode = hold_q.opcode;
  assign bus.alu_funct3 = hold_q.funct3;
  assign bus.alu_funct7 = hold_q.funct7;
endmodule

// File: tb/tb_tiny_rv_exec_ctrl.sv
// Directed + randomized bench for tiny_rv_exec_ctrl with a behavioural ALU and M-extension model.
module tb_tiny_rv_exec_ctrl;
  import tiny_rv_exec_pkg::*;

  localparam int         MD_ITERS = 32;
  localparam logic [6:0] AUIPC    = 7'b0010111;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, busy;
  int   errors = 0, checks = 0;

  tiny_rv_exec_ctrl_if bus();

  tiny_rv_exec_ctrl #(.MD_ITERS(MD_ITERS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  // External ALU: returns {active, result}.
  function automatic logic [32:0] ref_alu(input logic [31:0] pc, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] rb,
      input logic [31:0] imm);
    logic [31:0] b, r;
    b = (op == RV_ALUI) ? imm : rb;
    r = 32'd0;
    if (op == RV_LUI) return {1'b1, imm};
    if (op == AUIPC) return {1'b1, pc + imm};
    if (op == RV_ALUI || (op == RV_ALU && f7 != F7_MULDIV)) begin
      case (f3)
        3'd0: r = (op == RV_ALU && f7[5]) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = {31'd0, $signed(a) < $signed(b)};
        3'd3: r = {31'd0, a < b};
        3'd4: r = a ^ b;
        3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
      return {1'b1, r};
    end
    return 33'd0;
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb, ua, ub;
    logic [63:0] p;
    ia = a; ib = b; sa = ia; sb = ib; ua = {32'd0, a}; ub = {32'd0, b};
    p = 64'd0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a; else return ia / ib;
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0; else return ia % ib;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic logic is_m(input exec_req_t r);
    return r.opcode == RV_ALU && r.funct7 == 7'd1;
  endfunction

  function automatic logic [31:0] ref_result(input exec_req_t r);
    logic [32:0] al;
    al = ref_alu(r.pc, r.opcode, r.funct3, r.funct7, r.rs1, r.rs2, r.imm);
    return is_m(r) ? ref_md(r.funct3, r.rs1, r.rs2) : al[31:0];
  endfunction

  function automatic exec_req_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd);
    exec_req_t r;
    r = '{pc: 32'h0000_1000 + {27'd0, rd, 2'd0}, opcode: op, funct3: f3, funct7: f7,
          rs1: a, rs2: b, imm: imm, rd: rd};
    return r;
  endfunction

  always_comb {bus.alu_active, bus.alu_result} = ref_alu(bus.alu_pc, bus.alu_opcode, bus.alu_funct3,
                                                         bus.alu_funct7, bus.alu_rs1, bus.alu_rs2, bus.alu_imm);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input exec_req_t r);
    bus.in_valid = 1'b1; bus.in_pc = r.pc; bus.in_opcode = r.opcode; bus.in_funct3 = r.funct3;
    bus.in_funct7 = r.funct7; bus.in_rs1 = r.rs1; bus.in_rs2 = r.rs2; bus.in_imm = r.imm; bus.in_rd = r.rd;
  endtask

  // Starts in the cycle after the accept edge; checks latency and the response fields.
  task automatic collect(input exec_req_t r, input string tag, input logic [31:0] exp_data);
    logic [32:0] al;
    logic ill, special;
    int lat, elat;
    al = ref_alu(r.pc, r.opcode, r.funct3, r.funct7, r.rs1, r.rs2, r.imm);
    ill = !is_m(r) && !al[32];
    special = r.funct3[2] && (r.rs2 == 0 ||
              (!r.funct3[0] && r.rs1 == 32'h8000_0000 && r.rs2 == 32'hFFFF_FFFF));
    elat = (is_m(r) && !special) ? MD_ITERS + 2 : 1;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " data"}, bus.out_data, exp_data);
    chk({tag, " rd"}, {27'd0, bus.out_rd}, {27'd0, r.rd});
    chk({tag, " illegal"}, {31'd0, bus.out_illegal}, {31'd0, ill});
    chk({tag, " we"}, {31'd0, bus.out_we}, {31'd0, !ill && r.rd != 0});
  endtask

  task automatic run(input exec_req_t r, input string tag, input logic [31:0] exp_data, input bit bp);
    @(negedge clk);
    bus.out_ready = !bp;
    drive(r);
    chk({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    collect(r, tag, exp_data);
    if (bp) begin
      repeat (2) begin
        @(negedge clk);
        chk({tag, " bp valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, " bp data"}, bus.out_data, exp_data);
      end
      bus.out_ready = 1'b1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " out_data"}, bus.out_data, 32'd0);
    chk({tag, " out_rd"}, {27'd0, bus.out_rd}, 32'd0);
    chk({tag, " out_we"}, {31'd0, bus.out_we}, 32'd0);
    chk({tag, " out_illegal"}, {31'd0, bus.out_illegal}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " alu_rs1"}, bus.alu_rs1, 32'd0);
    chk({tag, " alu_imm"}, bus.alu_imm, 32'd0);
    chk({tag, " alu_opcode"}, {25'd0, bus.alu_opcode}, 32'd0);
  endtask

  initial begin
    exec_req_t r;
    logic [31:0] held;
    drive(mk(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset
    repeat (3) @(negedge clk);
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset in_ready after", {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back ALU ops at one per cycle
    @(negedge clk);
    drive(mk(RV_ALUI, 3'd0, 7'd0, 32'd5, 32'd0, 32'hFFFF_FFF9, 5'd3));
    @(posedge clk);
    @(negedge clk);
    chk("addi valid", {31'd0, bus.out_valid}, 32'd1);
    chk("addi data", bus.out_data, 32'hFFFF_FFFE);
    chk("addi we", {31'd0, bus.out_we}, 32'd1);
    chk("b2b in_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(mk(RV_ALU, 3'd0, 7'd0, 32'd10, 32'd20, 32'd0, 5'd4));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("add b2b valid", {31'd0, bus.out_valid}, 32'd1);
    chk("add b2b data", bus.out_data, 32'd30);
    chk("add b2b rd", {27'd0, bus.out_rd}, 32'd4);
    @(negedge clk);
    chk("b2b drained", {31'd0, bus.out_valid}, 32'd0);

    // ALU boundary cases
    run(mk(RV_ALU, 3'd0, 7'd0, 32'd1, 32'd2, 32'd0, 5'd0), "add rd0", 32'd3, 1'b0);
    run(mk(7'h7F, 3'd0, 7'd0, 32'd1, 32'd2, 32'd0, 5'd9), "illegal op", 32'd0, 1'b0);

    // Multiply / divide directed
    run(mk(RV_ALU, MD_MULH, 7'd1, 32'h8000_0000, 32'd2, 32'd0, 5'd5), "mulh", 32'hFFFF_FFFF, 1'b0);
    run(mk(RV_ALU, MD_MULHU, 7'd1, 32'h8000_0000, 32'd2, 32'd0, 5'd5), "mulhu", 32'h0000_0001, 1'b0);
    run(mk(RV_ALU, MD_DIV, 7'd1, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd6), "div", 32'hFFFF_FFFD, 1'b0);
    run(mk(RV_ALU, MD_REM, 7'd1, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd6), "rem", 32'hFFFF_FFFF, 1'b0);
    run(mk(RV_ALU, MD_DIVU, 7'd1, 32'd123, 32'd0, 32'd0, 5'd7), "divu by0", 32'hFFFF_FFFF, 1'b0);
    run(mk(RV_ALU, MD_DIV, 7'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd7), "div ovf", 32'h8000_0000, 1'b0);

    // Flush during MD_RUN
    @(negedge clk);
    drive(mk(RV_ALU, MD_DIVU, 7'd1, 32'd100, 32'd7, 32'd0, 5'd8));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    drive(mk(RV_ALUI, 3'd0, 7'd0, 32'd1, 32'd0, 32'd1, 5'd9));
    chk("flush in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 begin flush = 1'b0; bus.in_valid = 1'b0; end
    @(negedge clk);
    chk("flush out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush busy", {31'd0, busy}, 32'd0);
    run(mk(RV_ALUI, 3'd0, 7'd0, 32'd40, 32'd0, 32'd2, 5'd10), "post-flush addi", 32'd42, 1'b0);
    @(negedge clk);
    chk("post-flush drained", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(mk(RV_ALU, 3'd0, 7'd0, 32'd1234, 32'd1, 32'd0, 5'd7));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    held = bus.out_data;
    chk("bp first data", held, 32'd1235);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp valid held", {31'd0, bus.out_valid}, 32'd1);
      chk("bp data held", bus.out_data, 32'd1235);
      chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp single transfer", {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of MD_RUN
    @(negedge clk);
    drive(mk(RV_ALU, MD_MUL, 7'd1, 32'd77, 32'd3, 32'd5, 5'd11));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid-md reset");
    chk("mid-md reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;
    run(mk(RV_ALU, MD_MUL, 7'd1, 32'd77, 32'd3, 32'd0, 5'd11), "mul after reset", 32'd231, 1'b0);

    // Randomized mix against the reference model
    for (int n = 0; n < 30; n++) begin
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic [31:0] a, b;
      int cls;
      cls = $urandom_range(0, 3);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      case (cls)
        0: op = RV_ALUI;
        1: op = RV_ALU;
        2: begin op = RV_ALU; f7 = 7'd1; end
        default: case ($urandom_range(0, 2))
          0: op = RV_LUI;
          1: op = AUIPC;
          default: op = 7'h0B;
        endcase
      endcase
      r = mk(op, f3, f7, a, b, $urandom, 5'($urandom_range(0, 31)));
      run(r, $sformatf("rnd%0d", n), ref_result(r), $urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    chk("final idle", {31'd0, busy}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
